tcp_tx_arbiter: RTL and testbench

TCP_TX_ARBITER -- requirements
Module: tcp_tx_arbiter

---
 rtl/lynxTypes.sv | 24 ++
 rtl/tcp_rr_arb.sv | 49 ++++
 rtl/tcp_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_tcp_tx_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lynxTypes.sv
// Shared types for the TCP transmit path: the tx meta layout, the requester
// limit, the arbiter FSM states and a saturating counter helper.
package lynxTypes;

    localparam int N_REQ_MAX = 16;
    localparam int TID_BITS  = 4;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] sid;
    } tcp_tx_meta_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        DATA = 2'd2
    } tcp_tx_arb_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/tcp_rr_arb.sv
// Combinational round-robin pick: the first asserted request at or above
// rr_ptr wins; if there is none, the lowest asserted request below it wins.
module tcp_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         gnt_oh,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);
    localparam int IDX_W = $clog2(N_REQ);

    logic             found_hi_s;
    logic             found_lo_s;
    logic [IDX_W-1:0] idx_hi_s;
    logic [IDX_W-1:0] idx_lo_s;

    // Two priority scans (upper window, whole vector) merged into one grant.
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        idx_hi_s   = '0;
        idx_lo_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (i >= int'(rr_ptr)) && !found_hi_s) begin
                found_hi_s = 1'b1;
                idx_hi_s   = IDX_W'(i);
            end else begin
                found_hi_s = found_hi_s;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && !found_lo_s) begin
                found_lo_s = 1'b1;
                idx_lo_s   = IDX_W'(i);
            end else begin
                found_lo_s = found_lo_s;
            end
        end
        gnt_idx = found_hi_s ? idx_hi_s : idx_lo_s;
        gnt_oh  = '0;
        if (found_hi_s || found_lo_s) begin
            gnt_oh[gnt_idx] = 1'b1;
        end else begin
            gnt_oh = '0;
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Arbitrates N_REQ tx meta/payload requesters onto one meta channel and one
// AXI4-Stream. A winner keeps the path from its meta until its tlast beat,
// so payload always follows the meta of the same requester.
// Optional feature: define TCP_TX_ARB_STATS_EN to add per-requester
// saturating packet counters on output pkt_cnt.
module tcp_tx_arbiter
    import lynxTypes::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 512,
    parameter int META_BITS = 32
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [N_REQ-1:0]                      s_tx_meta_valid,
    output logic [N_REQ-1:0]                      s_tx_meta_ready,
    input  logic [N_REQ-1:0][META_BITS-1:0]       s_tx_meta_data,
    input  logic [N_REQ-1:0]                      s_axis_tx_tvalid,
    output logic [N_REQ-1:0]                      s_axis_tx_tready,
    input  logic [N_REQ-1:0][DATA_BITS-1:0]       s_axis_tx_tdata,
    input  logic [N_REQ-1:0][DATA_BITS/8-1:0]     s_axis_tx_tkeep,
    input  logic [N_REQ-1:0]                      s_axis_tx_tlast,
    output logic                                  m_tx_meta_valid,
    input  logic                                  m_tx_meta_ready,
    output logic [META_BITS-1:0]                  m_tx_meta_data,
    output logic                                  m_axis_tx_tvalid,
    input  logic                                  m_axis_tx_tready,
    output logic [DATA_BITS-1:0]                  m_axis_tx_tdata,
    output logic [DATA_BITS/8-1:0]                m_axis_tx_tkeep,
    output logic                                  m_axis_tx_tlast,
    output logic [TID_BITS-1:0]                   m_axis_tx_tid,
`ifdef TCP_TX_ARB_STATS_EN
    output logic [N_REQ-1:0][31:0]                pkt_cnt,
`endif
    output logic                                  busy
);
    localparam int IDX_W = $clog2(N_REQ);

    tcp_tx_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [META_BITS-1:0]   meta_q, meta_d;
    logic                   meta_valid_q, meta_valid_d;
    logic                   busy_q, busy_d;

    logic [N_REQ-1:0]       gnt_oh_s;
    logic [IDX_W-1:0]       gnt_idx_s;
    logic [META_BITS-1:0]   meta_sel_s;
    logic                   last_hs_s;

    tcp_rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
        .req     (s_tx_meta_valid),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (gnt_oh_s),
        .gnt_idx (gnt_idx_s)
    );

    // One-hot AND-OR select of the meta word belonging to the round-robin pick.
    always_comb begin
        meta_sel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh_s[i]) begin
                meta_sel_s = meta_sel_s | s_tx_meta_data[i];
            end else begin
                meta_sel_s = meta_sel_s;
            end
        end
    end

    // Payload mirror and ready steering: only the winner sees tready, and only in DATA.
    always_comb begin
        s_tx_meta_ready  = '0;
        s_axis_tx_tready = '0;
        m_axis_tx_tvalid = 1'b0;
        m_axis_tx_tdata  = '0;
        m_axis_tx_tkeep  = '0;
        m_axis_tx_tlast  = 1'b0;
        if ((state_q == META) && m_tx_meta_ready) begin
            s_tx_meta_ready[winner_q] = 1'b1;
        end else begin
            s_tx_meta_ready = '0;
        end
        if (state_q == DATA) begin
            m_axis_tx_tvalid           = s_axis_tx_tvalid[winner_q];
            m_axis_tx_tdata            = s_axis_tx_tdata[winner_q];
            m_axis_tx_tkeep            = s_axis_tx_tkeep[winner_q];
            m_axis_tx_tlast            = s_axis_tx_tlast[winner_q];
            s_axis_tx_tready[winner_q] = m_axis_tx_tready;
        end else begin
            s_axis_tx_tready = '0;
        end
    end

    assign last_hs_s       = m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_tlast;
    assign m_tx_meta_valid = meta_valid_q;
    assign m_tx_meta_data  = meta_q;
    assign m_axis_tx_tid   = TID_BITS'(winner_q);
    assign busy            = busy_q;

    // Next-state logic: IDLE grants, META waits for the meta handshake, DATA runs to tlast.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        rr_ptr_d     = rr_ptr_q;
        meta_d       = meta_q;
        meta_valid_d = meta_valid_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (|s_tx_meta_valid) begin
                    state_d      = META;
                    winner_d     = gnt_idx_s;
                    meta_d       = meta_sel_s;
                    meta_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            META: begin
                if (m_tx_meta_ready) begin
                    state_d      = DATA;
                    meta_valid_d = 1'b0;
                end else begin
                    state_d = META;
                end
            end
            DATA: begin
                if (last_hs_s) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    rr_ptr_d = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : (winner_q + IDX_W'(1));
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d      = IDLE;
                meta_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // FSM state and its registered outputs; reset abandons any packet in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            winner_q     <= '0;
            rr_ptr_q     <= '0;
            meta_q       <= '0;
            meta_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            rr_ptr_q     <= rr_ptr_d;
            meta_q       <= meta_d;
            meta_valid_q <= meta_valid_d;
            busy_q       <= busy_d;
        end
    end

`ifdef TCP_TX_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] pkt_cnt_q, pkt_cnt_d;

    // Count completed packets of the current winner, saturating at all-ones.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (last_hs_s && (winner_q == IDX_W'(i))) begin
                pkt_cnt_d[i] = sat_inc32(pkt_cnt_q[i]);
            end else begin
                pkt_cnt_d[i] = pkt_cnt_q[i];
            end
        end
    end

    // Packet counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Scoreboard bench for tcp_tx_arbiter: directed scenarios push the
// hand-derived meta words and payload beats in the expected grant order; a
// negedge monitor pops and compares on every handshake.
module tb_tcp_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int MW = 32;

    typedef struct packed {
        logic [3:0]    tid;
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic                  aclk = 1'b0;
    logic                  aresetn = 1'b0;
    logic [N-1:0]          s_tx_meta_valid, s_tx_meta_ready;
    logic [N-1:0][MW-1:0]  s_tx_meta_data;
    logic [N-1:0]          s_axis_tx_tvalid, s_axis_tx_tready, s_axis_tx_tlast;
    logic [N-1:0][DW-1:0]  s_axis_tx_tdata;
    logic [N-1:0][KW-1:0]  s_axis_tx_tkeep;
    logic                  m_tx_meta_valid, m_tx_meta_ready;
    logic [MW-1:0]         m_tx_meta_data;
    logic                  m_axis_tx_tvalid, m_axis_tx_tready, m_axis_tx_tlast;
    logic [DW-1:0]         m_axis_tx_tdata;
    logic [KW-1:0]         m_axis_tx_tkeep;
    logic [3:0]            m_axis_tx_tid;
    logic                  busy;
`ifdef TCP_TX_ARB_STATS_EN
    logic [N-1:0][31:0]    pkt_cnt;
`endif

    tcp_tx_arbiter #(.N_REQ(N), .DATA_BITS(DW), .META_BITS(MW)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_tx_meta_valid  (s_tx_meta_valid),
        .s_tx_meta_ready  (s_tx_meta_ready),
        .s_tx_meta_data   (s_tx_meta_data),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .m_tx_meta_valid  (m_tx_meta_valid),
        .m_tx_meta_ready  (m_tx_meta_ready),
        .m_tx_meta_data   (m_tx_meta_data),
        .m_axis_tx_tvalid (m_axis_tx_tvalid),
        .m_axis_tx_tready (m_axis_tx_tready),
        .m_axis_tx_tdata  (m_axis_tx_tdata),
        .m_axis_tx_tkeep  (m_axis_tx_tkeep),
        .m_axis_tx_tlast  (m_axis_tx_tlast),
        .m_axis_tx_tid    (m_axis_tx_tid),
`ifdef TCP_TX_ARB_STATS_EN
        .pkt_cnt          (pkt_cnt),
`endif
        .busy             (busy)
    );

    always #5 aclk = ~aclk;

    int            checks = 0;
    int            errors = 0;
    logic [MW-1:0] exp_meta_q[$];
    beat_t         exp_beat_q[$];

    // Requester source model state (written only by the main process).
    bit            mv[N];
    logic [MW-1:0] md[N];
    bit            tv[N];
    int            nb[N];
    int            bi[N];
    int            pk[N];
    bit            throttle;

    function automatic logic [DW-1:0] beat_word(input int r, input int p, input int b);
        return {16'hBEEF, 16'(r), 16'(p), 16'(b)};
    endfunction

    function automatic logic [KW-1:0] beat_keep(input bit last);
        return last ? 8'h0F : 8'hFF;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_tx_meta_valid[i]  = mv[i];
            s_tx_meta_data[i]   = md[i];
            s_axis_tx_tvalid[i] = tv[i];
            s_axis_tx_tdata[i]  = beat_word(i, pk[i], bi[i]);
            s_axis_tx_tkeep[i]  = beat_keep(bi[i] == nb[i] - 1);
            s_axis_tx_tlast[i]  = (bi[i] == nb[i] - 1);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [MW-1:0] mon_meta;
    beat_t         mon_beat;
    beat_t         mon_got;

    // Monitor: pop and compare on every meta and payload handshake.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_tx_meta_valid && m_tx_meta_ready) begin
                if (exp_meta_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL meta_unexpected: got %0h expected none", m_tx_meta_data);
                end else begin
                    mon_meta = exp_meta_q.pop_front();
                    chk("meta_word", m_tx_meta_data, mon_meta);
                end
                chk("meta_ack_onehot", $countones(s_tx_meta_ready), 1);
            end else begin
                chk("meta_ack_idle", s_tx_meta_ready, 0);
            end
            if (m_axis_tx_tvalid && m_axis_tx_tready) begin
                mon_got = {m_axis_tx_tid, m_axis_tx_tlast, m_axis_tx_tkeep, m_axis_tx_tdata};
                if (exp_beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got %0h expected none", mon_got);
                end else begin
                    mon_beat = exp_beat_q.pop_front();
                    chk("beat", mon_got, mon_beat);
                end
            end
        end
    end

    task automatic exp_m(input logic [MW-1:0] m);
        exp_meta_q.push_back(m);
    endtask

    task automatic exp_beats(input int r, input int n, input int cnt);
        beat_t e;
        for (int b = 0; b < cnt; b++) begin
            e.tid  = 4'(r);
            e.last = (b == n - 1);
            e.keep = beat_keep(b == n - 1);
            e.data = beat_word(r, pk[r], b);
            exp_beat_q.push_back(e);
        end
    endtask

    task automatic start_pkt(input int r, input logic [MW-1:0] m, input int n);
        pk[r] = pk[r] + 1;
        md[r] = m;
        nb[r] = n;
        bi[r] = 0;
        mv[r] = 1'b1;
        tv[r] = 1'b1;
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) p = p | mv[i] | tv[i];
        return p;
    endfunction

    // One clock: sample handshakes mid-cycle, advance the sources after the edge.
    task automatic step();
        bit mhs[N];
        bit bhs[N];
        @(negedge aclk);
        for (int i = 0; i < N; i++) begin
            mhs[i] = mv[i] && s_tx_meta_ready[i];
            bhs[i] = tv[i] && s_axis_tx_tready[i];
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (mhs[i]) mv[i] = 1'b0;
            if (bhs[i]) begin
                if (bi[i] == nb[i] - 1) begin
                    tv[i] = 1'b0;
                    bi[i] = 0;
                end else begin
                    bi[i] = bi[i] + 1;
                end
            end
        end
        m_axis_tx_tready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || pending()) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles expected < 300", name, n);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; tv[i] = 1'b0; bi[i] = 0; nb[i] = 1; md[i] = '0;
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) pk[i] = 0;
        clear_sources();
        throttle         = 1'b0;
        m_tx_meta_ready  = 1'b1;
        m_axis_tx_tready = 1'b1;
        aresetn          = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_meta_valid", m_tx_meta_valid, 0);
        chk("rst_meta_data", m_tx_meta_data, 0);
        chk("rst_tvalid", m_axis_tx_tvalid, 0);
        chk("rst_s_tready", s_axis_tx_tready, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Single request from 1: meta one cycle later, one beat with tid 1.
        start_pkt(1, 32'h0040_0005, 1);
        exp_m(32'h0040_0005);
        exp_beats(1, 1, 1);
        chk("grant_lat_pre", m_tx_meta_valid, 0);
        step();
        chk("grant_lat", m_tx_meta_valid, 1);
        chk("busy_meta", busy, 1);
        chk("meta_latched", m_tx_meta_data, 32'h0040_0005);
        chk("meta_phase_tvalid", m_axis_tx_tvalid, 0);
        wait_idle("single");
        chk("idle_busy", busy, 0);

        // rr_ptr=2 after requester 1: requests 0 and 2 -> 2 first, then 0.
        start_pkt(0, 32'h0010_0100, 1);
        start_pkt(2, 32'h0020_0200, 2);
        exp_m(32'h0020_0200); exp_beats(2, 2, 2);
        exp_m(32'h0010_0100); exp_beats(0, 1, 1);
        wait_idle("rr_ptr2");

        // rr_ptr=1 -> requester 2 alone moves rr_ptr to 3.
        start_pkt(2, 32'h0008_0022, 1);
        exp_m(32'h0008_0022); exp_beats(2, 1, 1);
        wait_idle("to_ptr3");

        // Wrap: rr_ptr=3, requests 0 and 3 -> 3 then 0; rr_ptr ends at 1.
        start_pkt(0, 32'h0011_0000, 1);
        start_pkt(3, 32'h0033_0003, 1);
        exp_m(32'h0033_0003); exp_beats(3, 1, 1);
        exp_m(32'h0011_0000); exp_beats(0, 1, 1);
        wait_idle("wrap");

        // rr_ptr=1 -> requester 3 alone brings rr_ptr back to 0.
        start_pkt(3, 32'h0004_0303, 1);
        exp_m(32'h0004_0303); exp_beats(3, 1, 1);
        wait_idle("to_ptr0");

        // All four, two beats each, throttled tready: order 0,1,2,3.
        throttle = 1'b1;
        for (int r = 0; r < N; r++) start_pkt(r, {16'(128), 16'(16 + r)}, 2);
        exp_m(32'h0080_0010); exp_beats(0, 2, 2);
        exp_m(32'h0080_0011); exp_beats(1, 2, 2);
        exp_m(32'h0080_0012); exp_beats(2, 2, 2);
        exp_m(32'h0080_0013); exp_beats(3, 2, 2);
        wait_idle("all_four");
        throttle = 1'b0;
        m_axis_tx_tready = 1'b1;

        // Meta backpressure for 5 cycles on requester 2 (rr_ptr ends at 3).
        m_tx_meta_ready = 1'b0;
        start_pkt(2, 32'h0040_0002, 1);
        exp_m(32'h0040_0002); exp_beats(2, 1, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_meta_valid", m_tx_meta_valid, 1);
            chk("bp_meta_stable", m_tx_meta_data, 32'h0040_0002);
            chk("bp_ack", s_tx_meta_ready, 0);
            chk("bp_no_beat", m_axis_tx_tvalid, 0);
            step();
        end
        m_tx_meta_ready = 1'b1;
        wait_idle("backpressure");

        // Reset after the 2nd of 4 beats from requester 0.
        start_pkt(0, 32'h0100_0000, 4);
        exp_m(32'h0100_0000); exp_beats(0, 4, 2);
        n = 0;
        while (bi[0] != 2 && n < 100) begin
            step();
            n++;
        end
        chk("mid_reach", n < 100, 1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_axis_tx_tvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_meta_valid", m_tx_meta_valid, 0);
        chk("mid_rst_s_tready", s_axis_tx_tready, 0);
        chk("mid_rst_meta_data", m_tx_meta_data, 0);
        chk("mid_rst_meta_q", exp_meta_q.size(), 0);
        chk("mid_rst_beat_q", exp_beat_q.size(), 0);
        clear_sources();
        @(posedge aclk); @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        // rr_ptr restarts at 0: requests 2 and 3 -> 2 first (stale 3 would pick 3).
        start_pkt(2, 32'h0020_0002, 1);
        start_pkt(3, 32'h0030_0003, 1);
        exp_m(32'h0020_0002); exp_beats(2, 1, 1);
        exp_m(32'h0030_0003); exp_beats(3, 1, 1);
        wait_idle("post_reset");

`ifdef TCP_TX_ARB_STATS_EN
        aresetn = 1'b0;
        #1;
        chk("cnt_rst", pkt_cnt, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int p = 0; p < 3; p++) begin
            start_pkt(0, 32'h0001_0000, 1);
            exp_m(32'h0001_0000); exp_beats(0, 1, 1);
            wait_idle("cnt_req0");
        end
        start_pkt(2, 32'h0001_0002, 2);
        exp_m(32'h0001_0002); exp_beats(2, 2, 2);
        wait_idle("cnt_req2");
        chk("pkt_cnt0", pkt_cnt[0], 3);
        chk("pkt_cnt1", pkt_cnt[1], 0);
        chk("pkt_cnt2", pkt_cnt[2], 1);
        chk("pkt_cnt3", pkt_cnt[3], 0);
`endif

        repeat (2) step();
        chk("end_meta_q", exp_meta_q.size(), 0);
        chk("end_beat_q", exp_beat_q.size(), 0);
        chk("end_busy", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
